// File: rtl/bin_to_bcd_if.sv
// rtl/bin_to_bcd_if.sv - start/busy/done handshake bundle between a binary producer and the BCD converter
//
// Signals:
//   start  producer -> converter  conversion request
//   bin    producer -> converter  unsigned binary value, sampled on the accepting edge
//   busy   converter -> producer  conversion in progress
//   done   converter -> producer  one-cycle pulse when bcd/ovf update
//   bcd    converter -> producer  packed BCD digits, digit 0 in bcd[3:0]
//   ovf    converter -> producer  last converted value exceeded 10^DIGITS-1
interface bin_to_bcd_if #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd,
        input  ovf
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd,
        output ovf
    );
endinterface

// File: rtl/bin_to_bcd.sv
// rtl/bin_to_bcd.sv - sequential double-dabble binary to packed BCD converter, one input bit per clock
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    bin_to_bcd_if.slave: start/bin in, busy/done/bcd/ovf out (all outputs registered)
//
// A conversion takes WIDTH shift cycles. bcd/ovf hold their previous values until the
// done edge; values above 10^DIGITS-1 saturate the display to all nines and raise ovf.
module bin_to_bcd #(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bin_to_bcd_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    function automatic logic [63:0] max_val(input int d);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < d; i++) begin
            v = v * 64'd10;
        end
        return v - 64'd1;
    endfunction

    localparam logic [63:0]   MAX_VAL = max_val(DIGITS);
    localparam logic [BW-1:0] ALL_NINES = {DIGITS{4'h9}};

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] binreg;
    logic [BW-1:0]    scratch;
    logic [CW-1:0]    cnt;
    logic             ovf_pending;

    logic             busy_r;
    logic             done_r;
    logic [BW-1:0]    bcd_r;
    logic             ovf_r;

    logic [BW-1:0]    adj;
    logic [BW-1:0]    shifted;

    // Add-3 on nibbles >= 5 so the following left shift carries correctly into the
    // next decimal digit; the top scratch bit falls off and is covered by saturation.
    always_comb begin
        adj = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
        shifted = {adj[BW-2:0], binreg[WIDTH-1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            binreg      <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            bcd_r       <= '0;
            ovf_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        binreg      <= bus.bin;
                        scratch     <= '0;
                        cnt         <= CW'(WIDTH);
                        ovf_pending <= (64'(bus.bin) > MAX_VAL);
                        busy_r      <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted;
                    binreg  <= {binreg[WIDTH-2:0], 1'b0};
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd_r  <= ovf_pending ? ALL_NINES : shifted;
                        ovf_r  <= ovf_pending;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.bcd  = bcd_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: doc/bin_to_bcd.md
# bin_to_bcd

Sequential shift-and-add-3 (double-dabble) converter that turns an unsigned binary count into packed BCD digits, one input bit per clock. It sits directly upstream of the seven-segment digit decoders: each 4-bit digit of its `bcd` output drives one decoder's BCD input. A start/busy/done handshake lets the producer (counter, ALU result, switch input) request a conversion. The displayed value only changes when a conversion completes.

## Interface
- `WIDTH`, 14: binary input width in bits.
- `DIGITS`, 4: number of BCD output digits. Max representable value is 10^DIGITS − 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `start`  input  1  conversion request; sampled on rising edge of `clk`.
- `bin`  input  WIDTH  unsigned binary value; sampled only on the accepting edge.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `bcd`/`ovf` update.
- `bcd`  output  4*DIGITS  packed result. Digit 0 (ones) is `bcd[3:0]`; digit k is `bcd[4k+3:4k]`.
- `ovf`  output  1  high if the last converted `bin` exceeded 10^DIGITS − 1.

## Operation
- Two-state FSM:
  - **IDLE**: `busy`=0. On an edge with `start`=1:
    - Capture `bin` into a shift register.
    - Clear the BCD scratch (4*DIGITS bits).
    - Load the bit counter with WIDTH.
    - Register `ovf_pending` = (`bin` > 10^DIGITS − 1).
    - Go to **SHIFT**.
  - **SHIFT**: `busy`=1. Each edge does two steps:
    - In the scratch, add 3 to every nibble whose value is ≥ 5.
    - Then shift {scratch, binreg} left by one bit and decrement the counter.
    - On the edge that performs the WIDTH-th shift:
      - Load the output register `bcd` from the post-shift scratch. If `ovf_pending`, force all digits to 9 instead (saturate).
      - Set `ovf` = `ovf_pending`.
      - Pulse `done`.
      - Return to **IDLE**.
- `start` while `busy`=1 is ignored; no queueing.
- `bcd` and `ovf` hold their previous values for the whole conversion. They change only on the `done` edge.
- Arithmetic rules:
  - Add-3 is per nibble and modulo 16. It cannot overflow, because the adjusted nibble is only ≤ 12 before the shift.
  - The scratch is exactly 4*DIGITS bits. Bits shifted out of the top are discarded; the saturation path covers that case.
- If 2^WIDTH − 1 ≤ 10^DIGITS − 1, `ovf` is constant 0. The comparator is still legal.

## Timing
- Reset values (asynchronous, immediate on `rst_n`=0):
  - State IDLE.
  - `busy`=0, `done`=0, `bcd`=0 (displays all zeros), `ovf`=0.
  - Counter and scratch 0.
- Latency:
  - `start` accepted at edge E0.
  - `busy` is high after E0 through E(WIDTH−1).
  - After E(WIDTH), `done`=1 for exactly one cycle, `bcd`/`ovf` valid, and `busy`=0.
  - With default parameters: 14 cycles from the accepting edge to `done`.
- Back-to-back: `start`=1 during the `done` cycle is accepted, since `busy`=0. The next `done` follows WIDTH cycles later. Maximum throughput is one conversion per WIDTH+1 cycles.
- Reset mid-conversion aborts the conversion:
  - No `done` pulse.
  - `bcd`/`ovf` return to 0.
  - The first accepted `start` after release restarts cleanly.
- `bin` may change freely while `busy`=1; only the value captured at E0 is converted.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then `bin`=0, `start` pulse → `busy` high for 14 cycles, then `done` one cycle with `bcd`=16'h0000 and `ovf`=0.
- `bin`=1234 → `bcd`=16'h1234, `ovf`=0. Then `bin`=9999 → `bcd`=16'h9999, `ovf`=0. Then `bin`=10 → `bcd`=16'h0010.
- `bin`=16383 → `bcd`=16'h9999, `ovf`=1. A following conversion of `bin`=42 → `bcd`=16'h0042, `ovf`=0.
- Start `bin`=500, then assert `start` with `bin`=777 on cycle 5 of `busy` → request ignored. A single `done` occurs with `bcd`=16'h0500, and `bcd` holds its old value until that `done`.
- Back-to-back: hold `start`=1 continuously with `bin`=8 then 9 → `done` pulses exactly 15 cycles apart with `bcd`=16'h0008 then 16'h0009.
- Convert `bin`=4321, then drop `rst_n` for 1 cycle at busy cycle 7 → no `done`, and `bcd`=0, `ovf`=0, `busy`=0 immediately. A new `start` with `bin`=4321 → `bcd`=16'h4321 after 14 cycles.
